// File: rtl/serdes_lane_bringup_sequencer.sv
// rtl/serdes_lane_bringup_sequencer.sv - per-lane GTY reset/bring-up sequencer gated on QPLL lock
module serdes_lane_bringup_sequencer #(
  parameter int NUM_LANES        = 3,
  parameter int RESET_CYCLES     = 16,
  parameter int TX_SETTLE_CYCLES = 1024,
  parameter int ALIGN_TIMEOUT    = 65536,
  parameter int ERR_WINDOW       = 4096,
  parameter int ERR_THRESHOLD    = 8
) (
  input  logic                   clk_156m25_i,
  input  logic                   rst_i,
  input  logic                   qpll_lock_i,
  input  logic [NUM_LANES-1:0]   lane_enable_i,
  input  logic [NUM_LANES-1:0]   rx_comma_is_aligned_i,
  input  logic [NUM_LANES-1:0]   rx_err_i,
  input  logic [NUM_LANES-1:0]   retrain_i,
  output logic [NUM_LANES-1:0]   tx_reset_o,
  output logic [NUM_LANES-1:0]   rx_reset_o,
  output logic [NUM_LANES-1:0]   lane_up_o,
  output logic [3*NUM_LANES-1:0] lane_state_o,
  output logic [8*NUM_LANES-1:0] retrain_count_o
);

  localparam int MAX_AB  = (RESET_CYCLES > TX_SETTLE_CYCLES) ? RESET_CYCLES : TX_SETTLE_CYCLES;
  localparam int MAX_CYC = (MAX_AB > ALIGN_TIMEOUT) ? MAX_AB : ALIGN_TIMEOUT;
  localparam int DWELL_W = $clog2(MAX_CYC) + 1;
  localparam int WIN_W   = $clog2(ERR_WINDOW + 1);
  localparam int ERR_W   = $clog2(ERR_THRESHOLD + 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TX_RST    = 3'd1,
    ST_TX_SETTLE = 3'd2,
    ST_RX_RST    = 3'd3,
    ST_RX_ALIGN  = 3'd4,
    ST_UP        = 3'd5
  } state_e;

  logic [1:0]           pll_sync_q;
  logic [NUM_LANES-1:0] algn_s1_q, algn_s2_q;
  logic [NUM_LANES-1:0] err_s1_q, err_s2_q;
  logic                 pll_ok;

  always_ff @(posedge clk_156m25_i or posedge rst_i) begin
    if (rst_i) begin
      pll_sync_q <= '0;
      algn_s1_q  <= '0;
      algn_s2_q  <= '0;
      err_s1_q   <= '0;
      err_s2_q   <= '0;
    end else begin
      pll_sync_q <= {pll_sync_q[0], qpll_lock_i};
      algn_s1_q  <= rx_comma_is_aligned_i;
      algn_s2_q  <= algn_s1_q;
      err_s1_q   <= rx_err_i;
      err_s2_q   <= err_s1_q;
    end
  end

  assign pll_ok = pll_sync_q[1];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    state_e             state_q, state_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [ERR_W-1:0]   errc_q, errc_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               tx_q, tx_d, rx_q, rx_d, up_q, up_d;
    logic               bump;

    always_comb begin
      state_d = state_q;
      bump    = 1'b0;
      // Loss of lock or enable overrides everything and never counts as a retrain
      if (!pll_ok || !lane_enable_i[g]) begin
        state_d = ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE:      state_d = ST_TX_RST;
          ST_TX_RST:    if (dwell_q == DWELL_W'(RESET_CYCLES - 1)) state_d = ST_TX_SETTLE;
          ST_TX_SETTLE: if (dwell_q == DWELL_W'(TX_SETTLE_CYCLES - 1)) state_d = ST_RX_RST;
          ST_RX_RST:    if (dwell_q == DWELL_W'(RESET_CYCLES - 1)) state_d = ST_RX_ALIGN;
          ST_RX_ALIGN: begin
            if (algn_s2_q[g]) begin
              state_d = ST_UP;
            end else if (dwell_q == DWELL_W'(ALIGN_TIMEOUT - 1)) begin
              state_d = ST_RX_RST;
              bump    = 1'b1;
            end
          end
          ST_UP: begin
            if (!algn_s2_q[g] || errc_q == ERR_W'(ERR_THRESHOLD) || retrain_i[g]) begin
              state_d = ST_RX_RST;
              bump    = 1'b1;
            end
          end
          default:      state_d = ST_IDLE;
        endcase
      end

      dwell_d = dwell_q;
      if (state_d != state_q) dwell_d = '0;
      else if (dwell_q != '1) dwell_d = dwell_q + 1'b1;

      cnt_d = cnt_q;
      if (bump && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;

      // Error window only runs while the lane stays UP; any entry starts it from zero
      win_d  = '0;
      errc_d = '0;
      if (state_q == ST_UP && state_d == ST_UP) begin
        if (win_q != WIN_W'(ERR_WINDOW - 1)) begin
          win_d  = win_q + 1'b1;
          errc_d = errc_q;
          if (err_s2_q[g] && errc_q != ERR_W'(ERR_THRESHOLD)) errc_d = errc_q + 1'b1;
        end
      end

      tx_d = (state_d == ST_IDLE) || (state_d == ST_TX_RST);
      rx_d = !((state_d == ST_RX_ALIGN) || (state_d == ST_UP));
      up_d = (state_d == ST_UP);
    end

    always_ff @(posedge clk_156m25_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= ST_IDLE;
        dwell_q <= '0;
        win_q   <= '0;
        errc_q  <= '0;
        cnt_q   <= '0;
        tx_q    <= 1'b1;
        rx_q    <= 1'b1;
        up_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        dwell_q <= dwell_d;
        win_q   <= win_d;
        errc_q  <= errc_d;
        cnt_q   <= cnt_d;
        tx_q    <= tx_d;
        rx_q    <= rx_d;
        up_q    <= up_d;
      end
    end

    assign tx_reset_o[g]            = tx_q;
    assign rx_reset_o[g]            = rx_q;
    assign lane_up_o[g]             = up_q;
    assign lane_state_o[3*g +: 3]   = state_q;
    assign retrain_count_o[8*g +: 8] = cnt_q;
  end

endmodule
